// File: rtl/adcclock_lock_supervisor.sv
// adcclock_lock_supervisor: ADC PLL reset sequencer and lock qualifier in the refclk domain.
// Define ADCCLOCK_SUP_TIMEOUT_EN to enable the WAIT_LOCK timeout and sticky timeout_err.
module adcclock_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOSS_W              = 8
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              relock_req,
    output logic              pll_rst,
    output logic              sys_rst_n,
    output logic              clocks_ready,
    output logic [LOSS_W-1:0] loss_count,
    output logic              timeout_err
);
    localparam int BASE_MAX = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
`ifdef ADCCLOCK_SUP_TIMEOUT_EN
    localparam int CNT_MAX = (LOCK_TIMEOUT_CYCLES > BASE_MAX) ? LOCK_TIMEOUT_CYCLES : BASE_MAX;
`else
    localparam int CNT_MAX = BASE_MAX;
`endif
    localparam int CW = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
`ifdef ADCCLOCK_SUP_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, READY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic          lk_m, lk_s, loss, clr;
`ifdef ADCCLOCK_SUP_TIMEOUT_EN
    logic          tmo;
`endif

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
        end
    end

    always_comb begin
        state_d = state_q;
        loss    = 1'b0;
`ifdef ADCCLOCK_SUP_TIMEOUT_EN
        tmo     = 1'b0;
`endif
        case (state_q)
            RESET_PLL: if (cnt == RST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lk_s) state_d = STABLE;
`ifdef ADCCLOCK_SUP_TIMEOUT_EN
                else if (cnt == TMO_LAST) begin
                    state_d = RESET_PLL;
                    tmo     = 1'b1;
                end
`endif
            end
            STABLE: state_d = !lk_s ? WAIT_LOCK : (cnt == STABLE_LAST) ? READY : STABLE;
            READY: begin
                if (!lk_s) begin
                    state_d = RESET_PLL;
                    loss    = 1'b1;
                end
            end
        endcase
        if (relock_req) state_d = RESET_PLL;
        // a relock request restarts the counter even when already in RESET_PLL
        clr = relock_req || (state_d != state_q);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_PLL;
            cnt        <= '0;
            loss_count <= '0;
        end else begin
            state_q <= state_d;
            cnt     <= clr ? '0 : cnt + 1'b1;
            if (loss && !(&loss_count)) loss_count <= loss_count + 1'b1;
        end
    end

`ifdef ADCCLOCK_SUP_TIMEOUT_EN
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) timeout_err <= 1'b0;
        else if (relock_req) timeout_err <= 1'b0;
        else if (tmo) timeout_err <= 1'b1;
    end
`else
    assign timeout_err = 1'b0;
`endif

    assign pll_rst      = (state_q == RESET_PLL);
    assign sys_rst_n    = (state_q == READY);
    assign clocks_ready = (state_q == READY);
endmodule
